// File: rtl/axis_packet_generator.sv
// AXI-Stream packet source: framed packets of programmable length/count with a deterministic byte pattern.
// Optional backpressure stall counter enabled by defining PKTGEN_STALL_COUNT_EN.
module axis_packet_generator #(
    parameter int DATA_BYTES = 32,
    parameter int LEN_W      = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    resentn,
    input  logic                    start,
    input  logic                    stop,
    input  logic [LEN_W-1:0]        pkt_len,
    input  logic [7:0]              num_packets,
    output logic [8*DATA_BYTES-1:0] axisout_tdata,
    output logic [DATA_BYTES-1:0]   axisout_tkeep,
    output logic                    axisout_tvalid,
    output logic                    axisout_tlast,
    input  logic                    axisout_tready,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              pkts_sent,
    output logic [31:0]             stall_count
);

    localparam int OFF_W  = $clog2(DATA_BYTES);
    localparam int BEAT_W = LEN_W - OFF_W;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    len_q;
    logic [7:0]          num_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   last_beat;
    logic [GAP_W-1:0]    gap_cnt;
    logic                run_start, run_end, beat_acc, pkt_acc, is_last;
    logic [DATA_BYTES-1:0] keep;
    logic [7:0]          base;

    function automatic logic [DATA_BYTES-1:0] last_keep(input logic [LEN_W-1:0] len);
        logic [OFF_W-1:0] rem;
        rem = len[OFF_W-1:0];
        if (rem == '0)
            return '1;
        return (DATA_BYTES'(1) << rem) - DATA_BYTES'(1);
    endfunction

    // Index of the final beat: ceil(len/DATA_BYTES) - 1
    assign last_beat = BEAT_W'((len_q - LEN_W'(1)) >> OFF_W);
    assign is_last   = (beat_cnt == last_beat);

    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        run_start      = 1'b0;
        run_end        = 1'b0;
        axisout_tvalid = (state == SEND);
        busy           = (state != IDLE);
        beat_acc       = (state == SEND) && axisout_tready;
        pkt_acc        = beat_acc && is_last;
        case (state)
            IDLE: begin
                if (start && pkt_len != '0) begin
                    run_start = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (pkt_acc) begin
                    if ((num_q != 8'd0 && pkts_sent + 8'd1 == num_q) || stop) begin
                        run_end   = 1'b1;
                        state_nxt = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt = SEND;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    run_end   = 1'b1;
                    state_nxt = IDLE;
                end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_nxt = SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn) begin
            len_q     <= '0;
            num_q     <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            pkts_sent <= '0;
            done      <= 1'b0;
        end else begin
            done    <= run_end;
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (run_start) begin
                len_q     <= pkt_len;
                num_q     <= num_packets;
                pkts_sent <= '0;
                beat_cnt  <= '0;
            end else if (beat_acc) begin
                beat_cnt <= pkt_acc ? '0 : beat_cnt + BEAT_W'(1);
                if (pkt_acc)
                    pkts_sent <= pkts_sent + 8'd1;
            end
        end
    end

    // Payload is a pure function of beat index, lane and packet index, so it holds while stalled
    always_comb begin
        axisout_tdata = '0;
        axisout_tkeep = '0;
        axisout_tlast = 1'b0;
        keep          = '0;
        base          = '0;
        if (state == SEND) begin
            keep          = is_last ? last_keep(len_q) : '1;
            base          = 8'(beat_cnt) << OFF_W;
            axisout_tkeep = keep;
            axisout_tlast = is_last;
            for (int k = 0; k < DATA_BYTES; k++) begin
                if (keep[k])
                    axisout_tdata[k*8 +: 8] = base + 8'(k) + pkts_sent;
            end
        end
    end

`ifdef PKTGEN_STALL_COUNT_EN
    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn)
            stall_count <= '0;
        else if (run_start)
            stall_count <= '0;
        else if (axisout_tvalid && !axisout_tready && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
    end
`else
    assign stall_count = '0;
`endif

endmodule
